// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one registered-output ALU among NUM_REQ requesters.
// Optional build macro ALU_ARB_URGENT_EN adds req_urgent priority filtering ahead of round-robin.

package alu_defs_pkg;
  typedef enum logic [4:0] {
    ADD    = 5'd0,
    SUB    = 5'd1,
    SLL    = 5'd2,
    SLT    = 5'd3,
    SLTU   = 5'd4,
    XOR    = 5'd5,
    SRL    = 5'd6,
    SRA    = 5'd7,
    OR     = 5'd8,
    AND    = 5'd9,
    MUL    = 5'd10,
    MULH   = 5'd11,
    MULHSU = 5'd12,
    MULHU  = 5'd13,
    DIV    = 5'd14,
    DIVU   = 5'd15,
    REM    = 5'd16,
    REMU   = 5'd17
  } op_t;
endpackage

module alu_share_arbiter
  import alu_defs_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req_valid,
  output logic [NUM_REQ-1:0]  req_ready,
  input  op_t                 req_op   [NUM_REQ],
  input  logic signed [31:0]  req_src1 [NUM_REQ],
  input  logic signed [31:0]  req_src2 [NUM_REQ],
`ifdef ALU_ARB_URGENT_EN
  input  logic [NUM_REQ-1:0]  req_urgent,
`endif
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ID_W-1:0]     rsp_id,
  output logic [31:0]         rsp_data,
  output op_t                 alu_op,
  output logic signed [31:0]  alu_src1,
  output logic signed [31:0]  alu_src2,
  input  logic [31:0]         alu_res,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUED = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t              state_reg;
  logic [ID_W-1:0]     rr_ptr_reg;
  logic [ID_W-1:0]     pend_id_reg;
  logic [ID_W-1:0]     hold_id_reg;
  logic [31:0]         hold_data_reg;

  logic [NUM_REQ-1:0]  elig;
  logic [NUM_REQ-1:0]  gnt_oh;
  logic [ID_W-1:0]     gnt_id;
  logic [ID_W-1:0]     scan_idx;
  int                  scan_sum;
  logic                found;
  logic                stall;
  logic                issue;

  assign stall = (state_reg == HOLD) | ((state_reg == ISSUED) & ~rsp_ready);

`ifdef ALU_ARB_URGENT_EN
  logic any_urgent;
  assign any_urgent = |(req_valid & req_urgent);
`endif

  // Eligible set: urgent requesters mask out the rest when any of them is valid.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
`ifdef ALU_ARB_URGENT_EN
      assign elig[gi] = req_valid[gi] & (req_urgent[gi] | ~any_urgent);
`else
      assign elig[gi] = req_valid[gi];
`endif
    end
  endgenerate

  // Scan from the slot after the last winner, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_oh   = '0;
    gnt_id   = '0;
    found    = 1'b0;
    scan_sum = 0;
    scan_idx = '0;
    if (!rst && !stall) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        scan_sum = int'(rr_ptr_reg) + k;
        scan_idx = ID_W'(scan_sum % NUM_REQ);
        if (!found && elig[scan_idx]) begin
          found            = 1'b1;
          gnt_oh[scan_idx] = 1'b1;
          gnt_id           = scan_idx;
        end
      end
    end
  end

  assign issue     = |gnt_oh;
  assign req_ready = gnt_oh;

  // Idle bus parks at ADD 0,0 so the ALU inputs do not toggle.
  always_comb begin
    alu_op   = ADD;
    alu_src1 = '0;
    alu_src2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i]) begin
        alu_op   = req_op[i];
        alu_src1 = req_src1[i];
        alu_src2 = req_src2[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= ID_W'(NUM_REQ - 1);
      pend_id_reg   <= '0;
      hold_id_reg   <= '0;
      hold_data_reg <= '0;
    end else begin
      if (issue) begin
        rr_ptr_reg  <= gnt_id;
        pend_id_reg <= gnt_id;
      end
      case (state_reg)
        IDLE: begin
          if (issue) state_reg <= ISSUED;
        end
        ISSUED: begin
          if (rsp_ready) begin
            state_reg <= issue ? ISSUED : IDLE;
          end else begin
            hold_data_reg <= alu_res;
            hold_id_reg   <= pend_id_reg;
            state_reg     <= HOLD;
          end
        end
        HOLD: begin
          if (rsp_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rsp_id    = '0;
    case (state_reg)
      ISSUED: begin
        rsp_valid = 1'b1;
        rsp_data  = alu_res;
        rsp_id    = pend_id_reg;
      end
      HOLD: begin
        rsp_valid = 1'b1;
        rsp_data  = hold_data_reg;
        rsp_id    = hold_id_reg;
      end
      default: ;
    endcase
  end

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed requests push expected responses,
// a negedge monitor pops and compares every accepted response.
`timescale 1ns/1ps
module tb_alu_share_arbiter;
  import alu_defs_pkg::*;

  localparam int N = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  op_t                req_op   [N];
  logic signed [31:0] req_src1 [N];
  logic signed [31:0] req_src2 [N];
`ifdef ALU_ARB_URGENT_EN
  logic [N-1:0]       req_urgent;
`endif
  logic               rsp_valid;
  logic               rsp_ready;
  logic [1:0]         rsp_id;
  logic [31:0]        rsp_data;
  op_t                alu_op;
  logic signed [31:0] alu_src1;
  logic signed [31:0] alu_src2;
  logic [31:0]        alu_res;
  logic               busy;

  int checks = 0;
  int errors = 0;
  int          exp_id_q[$];
  logic [31:0] exp_data_q[$];

  always #5 clk = ~clk;

  alu_share_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_src1  (req_src1),
    .req_src2  (req_src2),
`ifdef ALU_ARB_URGENT_EN
    .req_urgent(req_urgent),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .alu_op    (alu_op),
    .alu_src1  (alu_src1),
    .alu_src2  (alu_src2),
    .alu_res   (alu_res),
    .busy      (busy)
  );

  // Registered ALU: result appears the cycle after operands are presented.
  function automatic logic [31:0] alu_f(op_t op, logic [31:0] a, logic [31:0] b);
    logic [63:0] p;
    case (op)
      ADD:    return a + b;
      SUB:    return a - b;
      SLL:    return a << b[4:0];
      SLT:    return {31'b0, $signed(a) < $signed(b)};
      SLTU:   return {31'b0, a < b};
      XOR:    return a ^ b;
      SRL:    return a >> b[4:0];
      SRA:    return $signed(a) >>> b[4:0];
      OR:     return a | b;
      AND:    return a & b;
      MUL:    return a * b;
      MULH:   begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
      MULHSU: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
      MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      DIV:    return (b == 0) ? 32'hFFFF_FFFF : $signed(a) / $signed(b);
      DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      REM:    return (b == 0) ? a : $signed(a) % $signed(b);
      REMU:   return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) alu_res <= alu_f(alu_op, alu_src1, alu_src2);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int id, input logic [31:0] d);
    exp_id_q.push_back(id);
    exp_data_q.push_back(d);
  endtask

  task automatic set_req(input int i, input op_t op, input logic [31:0] a, input logic [31:0] b);
    req_op[i]   = op;
    req_src1[i] = a;
    req_src2[i] = b;
  endtask

  // Response monitor: scoreboard pop on acceptance, stability check while stalled.
  bit          hold_seen = 0;
  logic [31:0] hold_d;
  logic [1:0]  hold_i;
  int          pop_id;
  logic [31:0] pop_d;

  always @(negedge clk) begin
    if (rst) begin
      hold_seen = 0;
    end else begin
      if (hold_seen) begin
        chk("rsp_stable_valid", {31'b0, rsp_valid}, 32'd1);
        chk("rsp_stable_data", rsp_data, hold_d);
        chk("rsp_stable_id", {30'b0, rsp_id}, {30'b0, hold_i});
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_id_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got id %0d data 0x%08h, required no response", rsp_id, rsp_data);
        end else begin
          pop_id = exp_id_q.pop_front();
          pop_d  = exp_data_q.pop_front();
          $display("rsp id=%0d data=0x%08h (expected id=%0d data=0x%08h)", rsp_id, rsp_data, pop_id, pop_d);
          chk("rsp_id", {30'b0, rsp_id}, 32'(pop_id));
          chk("rsp_data", rsp_data, pop_d);
        end
        hold_seen = 0;
      end else if (rsp_valid) begin
        hold_seen = 1;
        hold_d    = rsp_data;
        hold_i    = rsp_id;
      end else begin
        hold_seen = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, ADD, 0, 0);
`ifdef ALU_ARB_URGENT_EN
    req_urgent = '0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {28'b0, req_ready}, 32'h0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_rsp_id", {30'b0, rsp_id}, 32'h0);
    step();
    rst = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("idle_req_ready", {28'b0, req_ready}, 32'h0);
    chk("idle_alu_op", {27'b0, alu_op}, {27'b0, ADD});
    chk("idle_alu_src1", alu_src1, 32'h0);

    // Single ADD from requester 0
    step();
    set_req(0, ADD, 5, 7);
    req_valid = 4'b0001;
    push(0, 32'd12);
    @(negedge clk);
    chk("t1_req_ready", {28'b0, req_ready}, 32'h1);
    chk("t1_alu_src1", alu_src1, 32'd5);
    chk("t1_alu_src2", alu_src2, 32'd7);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("t1_busy_issued", {31'b0, busy}, 32'h1);
    chk("t1_rsp_valid", {31'b0, rsp_valid}, 32'h1);
    step();
    @(negedge clk);
    chk("t1_busy_after", {31'b0, busy}, 32'h0);

    // All four valid: grants rotate 0,1,2,3 after a reset
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, ADD, 10 * i, i + 1);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      push(k % 4, 32'(11 * (k % 4) + 1));
      @(negedge clk);
      $display("grant cycle %0d req_ready=%b", k, req_ready);
      chk("t2_grant", {28'b0, req_ready}, 32'(1 << (k % 4)));
      step();
    end
    req_valid = '0;
    @(negedge clk);

    // SUB 3,10 with response back-pressure
    step();
    set_req(0, SUB, 3, 10);
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    push(0, 32'hFFFF_FFF9);
    @(negedge clk);
    chk("t3_grant", {28'b0, req_ready}, 32'h1);
    step();
    set_req(1, ADD, 1, 1);
    req_valid = 4'b0010;
    repeat (3) begin
      @(negedge clk);
      chk("t3_stall_ready", {28'b0, req_ready}, 32'h0);
      chk("t3_stall_data", rsp_data, 32'hFFFF_FFF9);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t3_accept_ready", {28'b0, req_ready}, 32'h0);
    step();
    push(1, 32'd2);
    @(negedge clk);
    chk("t3_regrant", {28'b0, req_ready}, 32'h2);
    chk("t3_idle_busy", {31'b0, busy}, 32'h0);
    step();
    req_valid = '0;
    @(negedge clk);

    // Back-to-back MULHU then DIV
    step();
    set_req(2, MULHU, 32'hFFFF_FFFF, 2);
    req_valid = 4'b0100;
    push(2, 32'h1);
    @(negedge clk);
    chk("t4_grant_mulhu", {28'b0, req_ready}, 32'h4);
    step();
    set_req(3, DIV, 7, 2);
    req_valid = 4'b1000;
    push(3, 32'h3);
    @(negedge clk);
    chk("t4_grant_div", {28'b0, req_ready}, 32'h8);
    step();
    req_valid = '0;
    @(negedge clk);

    // Asynchronous reset while holding a result
    step();
    set_req(0, ADD, 1, 1);
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("t5_grant", {28'b0, req_ready}, 32'h1);
    step();
    req_valid = '0;
    step();
    #1;
    chk("t5_hold_valid", {31'b0, rsp_valid}, 32'h1);
    rst = 1'b1;
    #1;
    chk("t5_async_valid", {31'b0, rsp_valid}, 32'h0);
    chk("t5_async_busy", {31'b0, busy}, 32'h0);
    step();
    rst = 1'b0;
    rsp_ready = 1'b1;
    set_req(1, ADD, 20, 22);
    set_req(3, ADD, 30, 3);
    req_valid = 4'b1010;
    push(1, 32'd42);
    @(negedge clk);
    chk("t5_first_grant", {28'b0, req_ready}, 32'h2);
    step();
    push(3, 32'd33);
    @(negedge clk);
    chk("t5_second_grant", {28'b0, req_ready}, 32'h8);
    step();
    req_valid = '0;
    @(negedge clk);

`ifdef ALU_ARB_URGENT_EN
    // Urgent requester overrides round-robin order
    step();
    set_req(0, ADD, 1, 2);
    set_req(2, ADD, 4, 5);
    req_valid  = 4'b0101;
    req_urgent = 4'b0100;
    push(2, 32'd9);
    @(negedge clk);
    chk("t6_urgent_grant", {28'b0, req_ready}, 32'h4);
    step();
    req_urgent = '0;
    push(0, 32'd3);
    @(negedge clk);
    chk("t6_plain_grant", {28'b0, req_ready}, 32'h1);
    step();
    req_valid = '0;
    @(negedge clk);
`endif

    step();
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && exp_id_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_id_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending responses, required 0", exp_id_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
